// File: rtl/shift_reg_ctrl.sv
// Round-robin byte serializer controller. It drives an external 8-bit right-shift
// register and streams the granted byte LSB-first on a valid/ready serial port.
module shift_reg_ctrl (
   input  logic       clock,
   input  logic       reset,
   input  logic       req0,
   input  logic [7:0] data0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic       sr_load,
   output logic [7:0] sr_d_in,
   input  logic [7:0] sr_q,
   output logic       ser_valid,
   output logic       ser_data,
   input  logic       ser_ready,
   output logic       busy,
   output logic       done,
   output logic       done_id
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   typedef struct packed {
      logic       id;
      logic [7:0] data;
   } grant_t;

   state_t     state;
   logic [2:0] bit_cnt;
   logic [7:0] hold;
   logic       gnt_id;
   logic       last_id;

   logic   req_any;
   grant_t grant;

   // On a tie the requester that was not served last wins.
   always_comb begin
      req_any    = req0 | req1;
      grant.id   = (req0 & req1) ? ~last_id : req1;
      grant.data = grant.id ? data1 : data0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= 3'd0;
         hold    <= 8'd0;
         gnt_id  <= 1'b0;
         last_id <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  hold    <= grant.data;
                  gnt_id  <= grant.id;
                  last_id <= grant.id;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               bit_cnt <= 3'd0;
               state   <= SHIFT;
            end
            SHIFT: begin
               if (ser_ready) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // A stalled sink is handled by reloading the register with its own output.
   always_comb begin
      ack0      = 1'b0;
      ack1      = 1'b0;
      sr_load   = 1'b0;
      sr_d_in   = 8'd0;
      ser_valid = 1'b0;
      ser_data  = 1'b0;
      done      = 1'b0;
      done_id   = 1'b0;
      busy      = (state != IDLE);
      case (state)
         LOAD: begin
            sr_load = 1'b1;
            sr_d_in = hold;
            ack0    = ~gnt_id;
            ack1    = gnt_id;
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_data  = sr_q[0];
            if (!ser_ready) begin
               sr_load = 1'b1;
               sr_d_in = sr_q;
            end
         end
         DONE: begin
            done    = 1'b1;
            done_id = gnt_id;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl: a behavioural shift register sits beside the DUT and
// a monitor compares every ack, serial bit and done against a queue of expected bytes.
module tb_shift_reg_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [7:0] data0 = 8'd0, data1 = 8'd0;
   logic       ack0, ack1, sr_load, ser_valid, ser_data, busy, done, done_id;
   logic [7:0] sr_d_in;
   logic [7:0] sr_q;
   logic       ser_ready = 1'b1;

   int vectors = 0;
   int errors  = 0;

   typedef struct {
      logic       id;
      logic [7:0] data;
   } xfer_t;

   xfer_t exp_q[$];
   bit    active = 0;
   int    nbits  = 0;

   shift_reg_ctrl dut (
      .clock(clock), .reset(reset),
      .req0(req0), .data0(data0), .req1(req1), .data1(data1),
      .ack0(ack0), .ack1(ack1),
      .sr_load(sr_load), .sr_d_in(sr_d_in), .sr_q(sr_q),
      .ser_valid(ser_valid), .ser_data(ser_data), .ser_ready(ser_ready),
      .busy(busy), .done(done), .done_id(done_id)
   );

   always #5 clock = ~clock;

   // Independent model of the shift register the controller drives.
   always @(posedge clock) begin
      if (reset)        sr_q <= 8'd0;
      else if (sr_load) sr_q <= sr_d_in;
      else              sr_q <= {1'b0, sr_q[7:1]};
   end

   // Scoreboard monitor: pop an expected byte when it completes (or is aborted).
   always @(negedge clock) begin
      if (reset) begin
         if (active && exp_q.size() > 0) void'(exp_q.pop_front());
         active = 0;
      end else begin
         if (ack0 || ack1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL ack_unexpected got ack0=%0b ack1=%0b want none", ack0, ack1);
            end else if ((ack0 && ack1) || ack1 !== exp_q[0].id) begin
               errors++; $display("FAIL ack_id got ack0=%0b ack1=%0b want id %0d", ack0, ack1, exp_q[0].id);
            end
            active = 1; nbits = 0;
         end
         if (ser_valid && ser_ready) begin
            vectors++;
            if (!active || nbits > 7 || exp_q.size() == 0) begin
               errors++; $display("FAIL bit_unexpected got bit %0b at index %0d", ser_data, nbits);
            end else if (ser_data !== exp_q[0].data[nbits]) begin
               errors++; $display("FAIL ser_bit[%0d] got %0b want %0b", nbits, ser_data, exp_q[0].data[nbits]);
            end
            nbits++;
         end
         if (done) begin
            vectors++;
            if (!active || exp_q.size() == 0) begin
               errors++; $display("FAIL done_unexpected got done=1 want 0");
            end else begin
               if (done_id !== exp_q[0].id || nbits != 8) begin
                  errors++; $display("FAIL done_id got id %0b bits %0d want id %0b bits 8", done_id, nbits, exp_q[0].id);
               end
               void'(exp_q.pop_front());
            end
            active = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic push(input logic id, input logic [7:0] d);
      xfer_t x;
      x.id = id; x.data = d;
      exp_q.push_back(x);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin tick(); n++; end
      vectors++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL idle_timeout got busy=%0b want 0", busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; tick(); tick(); reset = 1'b0; #1;
      vectors++;
      if ({ack0, ack1, sr_load, sr_d_in, ser_valid, ser_data, busy, done, done_id} !== 16'd0 || sr_q !== 8'd0) begin
         errors++; $display("FAIL reset_outputs got busy=%0b sr_load=%0b sr_q=%h want all 0", busy, sr_load, sr_q);
      end
   endtask

   task automatic test_basic();
      logic [7:0] b = 8'hA5;
      push(1'b0, b);
      req0 = 1'b1; data0 = b;
      tick(); req0 = 1'b0; #1;
      vectors++;
      if (ack0 !== 1'b1 || ack1 !== 1'b0 || sr_load !== 1'b1 || sr_d_in !== b) begin
         errors++; $display("FAIL basic_load got ack0=%0b sr_load=%0b sr_d_in=%h want 1 1 %h", ack0, sr_load, sr_d_in, b);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         vectors++;
         if (ser_valid !== 1'b1 || ser_data !== b[k] || done !== 1'b0) begin
            errors++; $display("FAIL basic_bit%0d got valid=%0b data=%0b want 1 %0b", k, ser_valid, ser_data, b[k]);
         end
      end
      tick();
      vectors++;
      if (done !== 1'b1 || done_id !== 1'b0 || ser_valid !== 1'b0) begin
         errors++; $display("FAIL basic_done got done=%0b id=%0b want 1 0", done, done_id);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL basic_idle got busy=%0b done=%0b want 0 0", busy, done);
      end
   endtask

   task automatic test_alternate();
      logic exp_id;
      test_reset();
      for (int i = 0; i < 4; i++) push(i[0], i[0] ? 8'h80 : 8'h01);
      req0 = 1'b1; req1 = 1'b1; data0 = 8'h01; data1 = 8'h80;
      for (int i = 0; i < 4; i++) begin
         int n = 0;
         exp_id = i[0];
         while (!(ack0 || ack1) && n < 20) begin tick(); n++; end
         vectors++;
         if (ack0 !== ~exp_id || ack1 !== exp_id) begin
            errors++; $display("FAIL alt_grant%0d got ack0=%0b ack1=%0b want id %0b", i, ack0, ack1, exp_id);
         end
         if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
         tick();
         vectors++;
         if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
            errors++; $display("FAIL alt_ack_pulse%0d got ack0=%0b ack1=%0b want 0 0", i, ack0, ack1);
         end
      end
      wait_idle();
   endtask

   task automatic test_stall();
      logic prev = 1'b0;
      push(1'b1, 8'h3C);
      req1 = 1'b1; data1 = 8'h3C;
      for (int c = 1; c <= 13; c++) begin
         tick();
         if (c == 1) req1 = 1'b0;
         ser_ready = !(c == 3 || c == 4 || c == 7);
         #1;
         if (!ser_ready) begin
            vectors++;
            if (sr_load !== 1'b1 || sr_d_in !== sr_q || ser_data !== prev || ser_valid !== 1'b1) begin
               errors++; $display("FAIL stall_c%0d got load=%0b d_in=%h q=%h bit=%0b want 1 %h %h %0b", c, sr_load, sr_d_in, sr_q, ser_data, sr_q, sr_q, prev);
            end
         end
         vectors++;
         if (done !== (c == 13) || (c == 13 && done_id !== 1'b1)) begin
            errors++; $display("FAIL stall_done_c%0d got done=%0b id=%0b want %0b", c, done, done_id, c == 13);
         end
         prev = ser_data;
      end
      ser_ready = 1'b1;
      tick();
   endtask

   task automatic test_abort();
      push(1'b0, 8'hFF);
      req0 = 1'b1; data0 = 8'hFF;
      tick(); req0 = 1'b0;
      for (int c = 2; c <= 5; c++) tick();
      reset = 1'b1;
      tick(); reset = 1'b0; #1;
      vectors++;
      if (busy !== 1'b0 || sr_q !== 8'd0 || done !== 1'b0 || ack0 !== 1'b0) begin
         errors++; $display("FAIL abort got busy=%0b sr_q=%h done=%0b want 0 00 0", busy, sr_q, done);
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         vectors++;
         if (done !== 1'b0) begin
            errors++; $display("FAIL abort_no_done got done=1 want 0");
         end
      end
      push(1'b0, 8'h96);
      req0 = 1'b1; data0 = 8'h96;
      tick(); req0 = 1'b0;
      wait_idle();
   endtask

   task automatic test_ignore();
      push(1'b0, 8'h3A);
      req0 = 1'b1; data0 = 8'h3A;
      tick(); req0 = 1'b0;
      tick();
      tick();
      push(1'b1, 8'hC3);
      req1 = 1'b1; data1 = 8'hC3;
      for (int c = 3; c <= 10; c++) begin
         #1;
         vectors++;
         if (ack1 !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL ignore_c%0d got ack1=%0b busy=%0b want 0 1", c, ack1, busy);
         end
         tick();
      end
      tick();
      vectors++;
      if (ack1 !== 1'b1) begin
         errors++; $display("FAIL ignore_grant got ack1=%0b want 1", ack1);
      end
      req1 = 1'b0; req0 = 1'b1; data0 = 8'hEE;
      for (int c = 13; c <= 14; c++) begin
         tick();
         vectors++;
         if (ack0 !== 1'b0) begin
            errors++; $display("FAIL late_req_c%0d got ack0=%0b want 0", c, ack0);
         end
      end
      req0 = 1'b0;
      wait_idle();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) push(1'b0, 8'h55);
      req0 = 1'b1; data0 = 8'h55;
      for (int c = 0; c < 30; c++) begin
         #1;
         vectors++;
         if (busy !== (c % 11 != 0)) begin
            errors++; $display("FAIL b2b_busy_c%0d got %0b want %0b", c, busy, c % 11 != 0);
         end
         tick();
      end
      req0 = 1'b0;
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_alternate();
      test_stall();
      test_abort();
      test_ignore();
      test_back_to_back();
      tick(); tick();
      vectors++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
